// File: rtl/text_scroll_ctrl.sv
// text_scroll_ctrl: buffers an ASCII message and scrolls it right-to-left
// across NUM_DIGITS character positions, one position per TICK_DIV cycles.
// IDLE accepts characters and start/clear; SCROLL steps the display until the
// message has fully left the display, then loops or returns to IDLE.
module text_scroll_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BUF_DEPTH  = 16,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          char_valid,
  input  logic [7:0]                    char_data,
  output logic                          char_ready,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          loop_en,
  output logic [NUM_DIGITS*8-1:0]       digits,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(BUF_DEPTH):0]    count
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = $clog2(BUF_DEPTH + NUM_DIGITS + 1);

  localparam logic [NUM_DIGITS*8-1:0] BLANK = {NUM_DIGITS{8'h20}};

  typedef enum logic {
    IDLE,
    SCROLL
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [7:0]              r_buf [BUF_DEPTH];
  logic [CW-1:0]           r_count;
  logic [TW-1:0]           r_tick;
  logic [IW-1:0]           r_idx;
  logic [NUM_DIGITS*8-1:0] r_digits;
  logic                    r_done;

  logic                    w_char_ready;
  logic                    w_write;
  logic [CW-1:0]           w_count_next;
  logic                    w_start_ok;
  logic                    w_step;
  logic [IW-1:0]           w_pass_last;
  logic                    w_pass_end;
  logic [7:0]              w_load;

  assign w_char_ready = (r_state == IDLE) && (r_count < CW'(BUF_DEPTH)) && !clear;
  assign w_write      = char_valid && w_char_ready;
  assign w_count_next = r_count + CW'(w_write);
  // A character accepted in the same cycle as start counts towards the message.
  assign w_start_ok   = (r_state == IDLE) && start && !clear && (w_count_next != '0);
  assign w_step       = (r_state == SCROLL) && (r_tick == TW'(TICK_DIV - 1));
  assign w_pass_last  = IW'(r_count) + IW'(NUM_DIGITS - 1);
  assign w_pass_end   = w_step && (r_idx == w_pass_last);
  assign w_load       = (r_idx < IW'(r_count)) ? r_buf[r_idx[AW-1:0]] : 8'h20;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: clear aborts a scroll; a non-looping pass end returns to IDLE
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:   if (w_start_ok) w_state_next = SCROLL;
      SCROLL: begin
        if (clear)                       w_state_next = IDLE;
        else if (w_pass_end && !loop_en) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (r_state == SCROLL);
    char_ready = w_char_ready;
  end

  assign digits = r_digits;
  assign done   = r_done;
  assign count  = r_count;

  // Message storage; contents survive reset and clear, only count is cleared
  always_ff @(posedge clk) begin
    if (w_write) r_buf[r_count[AW-1:0]] <= char_data;
  end

  // Datapath: fill count, tick divider, read index, display shift register, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_tick   <= '0;
      r_idx    <= '0;
      r_digits <= BLANK;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == IDLE) && clear) r_count <= '0;
      else                            r_count <= w_count_next;

      unique case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_digits <= BLANK;
            r_tick   <= '0;
            r_idx    <= '0;
          end
        end
        SCROLL: begin
          if (clear) begin
            r_digits <= BLANK;
            r_tick   <= '0;
            r_idx    <= '0;
          end else if (w_step) begin
            r_tick   <= '0;
            r_digits <= {r_digits[NUM_DIGITS*8-9:0], w_load};
            if (w_pass_end) begin
              r_idx  <= '0;
              r_done <= !loop_en;
            end else begin
              r_idx  <= r_idx + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_scroll_ctrl.sv
// tb_text_scroll_ctrl: scoreboard bench for text_scroll_ctrl with a 4-digit,
// 4-character, 3-cycle-per-step configuration.
module tb_text_scroll_ctrl;

  localparam int ND   = 4;
  localparam int BD   = 4;
  localparam int TICK = 3;

  logic          clk;
  logic          rst;
  logic          char_valid;
  logic [7:0]    char_data;
  logic          char_ready;
  logic          start;
  logic          clear;
  logic          loop_en;
  logic [31:0]   digits;
  logic          busy;
  logic          done;
  logic [2:0]    count;

  int            n_checks;
  int            n_fail;
  logic [31:0]   q_exp[$];
  logic [31:0]   r_prev;

  text_scroll_ctrl #(
    .NUM_DIGITS (ND),
    .BUF_DEPTH  (BD),
    .TICK_DIV   (TICK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .start      (start),
    .clear      (clear),
    .loop_en    (loop_en),
    .digits     (digits),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Drive one character for one cycle; char_valid is left high for back-to-back use.
  task automatic write_char(input logic [7:0] c, input logic exp_ready);
    char_valid = 1'b1;
    char_data  = c;
    #1;
    check("char_ready", char_ready, exp_ready);
    step_clk();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_blank", digits, "    ");
    r_prev = "    ";
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
  endtask

  // Each step is due exactly TICK cycles after the previous one; digits must
  // hold in between and match the scoreboard on the step cycle.
  task automatic scroll_steps(input int n, input bit last_done);
    logic [31:0] exp;
    for (int k = 1; k <= n; k++) begin
      repeat (TICK - 1) begin
        step_clk();
        check("hold", digits, r_prev);
      end
      step_clk();
      exp = (q_exp.size() != 0) ? q_exp.pop_front() : 32'hDEAD_BEEF;
      check("step", digits, exp);
      r_prev = exp;
      if (k == n && last_done) begin
        check("done_pulse", done, 1);
      end else begin
        check("no_done", done, 0);
        check("busy_high", busy, 1);
      end
    end
    check("sb_left", q_exp.size(), 0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    start      = 1'b0;
    clear      = 1'b0;
    loop_en    = 1'b0;
    r_prev     = "    ";

    // Reset state
    repeat (2) step_clk();
    check("rst_digits", digits, "    ");
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    rst = 1'b0;
    step_clk();
    check("idle_ready", char_ready, 1);

    // "HI", single pass
    write_char("H", 1);
    write_char("I", 1);
    char_valid = 1'b0;
    check("hi_count", count, 2);
    q_exp.push_back("   H"); q_exp.push_back("  HI"); q_exp.push_back(" HI ");
    q_exp.push_back("HI  "); q_exp.push_back("I   "); q_exp.push_back("    ");
    pulse_start();
    scroll_steps(6, 1);
    step_clk();
    check("hi_done_end", done, 0);
    check("hi_busy_end", busy, 0);
    check("hi_count_kept", count, 2);

    // Clear in IDLE blocks writes, then fill past capacity
    clear = 1'b1;
    #1;
    check("clear_ready", char_ready, 0);
    step_clk();
    clear = 1'b0;
    check("clear_count", count, 0);
    write_char("A", 1);
    write_char("B", 1);
    write_char("C", 1);
    write_char("D", 1);
    write_char("E", 0);
    char_valid = 1'b0;
    check("full_count", count, 4);
    check("full_ready", char_ready, 0);
    q_exp.push_back("   A"); q_exp.push_back("  AB"); q_exp.push_back(" ABC");
    q_exp.push_back("ABCD"); q_exp.push_back("BCD "); q_exp.push_back("CD  ");
    q_exp.push_back("D   "); q_exp.push_back("    ");
    pulse_start();
    scroll_steps(8, 1);
    step_clk();
    check("full_busy_end", busy, 0);
    check("full_count_kept", count, 4);

    // "AB" looping: step 7 wraps straight back to "A" with no done
    pulse_clear();
    write_char("A", 1);
    write_char("B", 1);
    char_valid = 1'b0;
    loop_en = 1'b1;
    q_exp.push_back("   A"); q_exp.push_back("  AB"); q_exp.push_back(" AB ");
    q_exp.push_back("AB  "); q_exp.push_back("B   "); q_exp.push_back("    ");
    q_exp.push_back("   A"); q_exp.push_back("  AB");
    pulse_start();
    scroll_steps(8, 0);
    pulse_clear();
    loop_en = 1'b0;
    check("loop_abort_busy", busy, 0);
    check("loop_abort_count", count, 2);

    // Clear one cycle after step 2, then replay from the first character
    q_exp.push_back("   A"); q_exp.push_back("  AB");
    pulse_start();
    scroll_steps(2, 0);
    step_clk();
    check("pre_clear_hold", digits, "  AB");
    pulse_clear();
    check("abort_busy", busy, 0);
    check("abort_digits", digits, "    ");
    check("abort_count", count, 2);
    check("abort_done", done, 0);
    repeat (TICK) begin
      step_clk();
      check("abort_no_done", done, 0);
    end
    q_exp.push_back("   A");
    pulse_start();
    scroll_steps(1, 0);
    pulse_clear();

    // Start with an empty buffer is ignored
    pulse_clear();
    start = 1'b1;
    step_clk();
    start = 1'b0;
    check("empty_start_busy", busy, 0);
    repeat (TICK) step_clk();
    check("empty_start_digits", digits, "    ");
    check("empty_start_busy2", busy, 0);

    // Start together with clear: clear wins and empties the buffer
    write_char("X", 1);
    write_char("Y", 1);
    write_char("Z", 1);
    char_valid = 1'b0;
    check("xyz_count", count, 3);
    start = 1'b1;
    clear = 1'b1;
    step_clk();
    start = 1'b0;
    clear = 1'b0;
    check("startclr_busy", busy, 0);
    check("startclr_count", count, 0);

    // Asynchronous reset mid-step
    write_char("X", 1);
    write_char("Y", 1);
    write_char("Z", 1);
    char_valid = 1'b0;
    q_exp.push_back("   X");
    pulse_start();
    scroll_steps(1, 0);
    step_clk();
    #2;
    rst = 1'b1;
    #1;
    check("arst_digits", digits, "    ");
    check("arst_busy", busy, 0);
    check("arst_count", count, 0);
    check("arst_done", done, 0);
    step_clk();
    rst = 1'b0;
    start = 1'b1;
    #1;
    check("post_rst_ready", char_ready, 1);
    step_clk();
    start = 1'b0;
    check("post_rst_busy", busy, 0);
    repeat (2 * TICK) begin
      step_clk();
      check("post_rst_no_done", done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_scroll_ctrl.md
TEXT_SCROLL_CTRL -- requirements
Module: text_scroll_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of 7-segment digit positions driven.
REQ-002 SHALL have parameter BUF_DEPTH, default 16: message buffer capacity in characters (power of 2, >= 2).
REQ-003 SHALL have parameter TICK_DIV, default 25000000: clock cycles per scroll step (>= 2).
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port char_valid, input, 1: write request for char_data.
REQ-007 SHALL have port char_data, input, 8: ASCII character to append to the buffer.
REQ-008 SHALL have port char_ready, output, 1: buffer can accept a character this cycle.
REQ-009 SHALL have port start, input, 1: single-cycle request to begin scrolling the buffered message.
REQ-010 SHALL have port clear, input, 1: empty the buffer (IDLE) or abort scrolling (SCROLL).
REQ-011 SHALL have port loop_en, input, 1: repeat the message indefinitely when high, sampled at end of each pass.
REQ-012 SHALL have port digits, output, NUM_DIGITS*8: ASCII code per digit, digit 0 (rightmost) in bits [7:0], one ASCII-to-7-segment decoder instance per byte.
REQ-013 SHALL have port busy, output, 1: high while in SCROLL.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a non-looping pass completes.
REQ-015 SHALL have port count, output, $clog2(BUF_DEPTH)+1: number of characters held.

Function
REQ-016 SHALL implement states IDLE and SCROLL only; registered outputs throughout.
REQ-017 SHALL drive char_ready = (state==IDLE) && (count<BUF_DEPTH) && !clear, combinationally.
REQ-018 SHALL append char_data at index count and increment count on each cycle with char_valid && char_ready; no write otherwise.
REQ-019 SHALL on clear in IDLE set count to 0 next cycle; clear beats start and write in the same cycle.
REQ-020 SHALL on start in IDLE with count>0 (including a write accepted that same cycle) enter SCROLL, set digits all 8'h20, reset tick counter and read index to 0; start with resulting count 0 ignored.
REQ-021 SHALL in SCROLL count 0..TICK_DIV-1 and perform one step on the cycle the counter equals TICK_DIV-1, then wrap to 0; first step TICK_DIV cycles after the start cycle.
REQ-022 SHALL per step shift digits left one byte (digit NUM_DIGITS-1 discarded) and load digit 0 with buffer[index] while index<count, else 8'h20; index increments each step.
REQ-023 SHALL complete a pass after count+NUM_DIGITS steps (message fully scrolled out, all digits 8'h20).
REQ-024 SHALL at pass end with loop_en=1 reset index to 0 and stay in SCROLL with no idle gap; with loop_en=0 return to IDLE and pulse done for exactly that cycle.
REQ-025 SHALL ignore start and char_valid in SCROLL; buffer contents and count unchanged by scrolling.
REQ-026 SHALL on clear in SCROLL return to IDLE next cycle, set digits all 8'h20, keep buffer and count, no done pulse.
REQ-027 SHALL drive busy = (state==SCROLL).

Reset
REQ-028 SHALL on rst, regardless of clock: state IDLE, count 0, digits all 8'h20, done 0, busy 0, tick counter and index 0; buffer contents need not be cleared.
REQ-029 SHALL on rst mid-SCROLL abandon the pass with no done pulse; first post-reset cycle behaves as IDLE with empty buffer.

Verification (bench: NUM_DIGITS=4, BUF_DEPTH=4, TICK_DIV=3)
REQ-030 SHALL cover: write "HI" then start, loop_en=0 -> digits after steps 1..6: "   H","  HI"," HI ","HI  ","I   ","    "; done pulses on step-6 cycle; busy low next cycle; count stays 2.
REQ-031 SHALL cover: write 5 chars "ABCDE" back-to-back -> char_ready low after 4th accepted, count=4, "E" dropped.
REQ-032 SHALL cover: "AB", loop_en=1 -> after step 6 step 7 loads "A" 3 cycles later, no done pulse, busy stays high.
REQ-033 SHALL cover: clear asserted 1 cycle after step 2 -> IDLE next cycle, digits "    ", count=2, no done; start again replays from "A"/first char.
REQ-034 SHALL cover: start with count=0, and start+clear together with count=3 -> both stay IDLE, busy 0; latter leaves count=0.
REQ-035 SHALL cover: rst asserted asynchronously mid-step with count=3 -> outputs at reset values immediately, count=0, done never pulses.
